// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register addresses, field positions and masks.
package exc_ctrl_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef enum logic {
    S_IDLE,
    S_REDIR
  } exc_state_e;

  // {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [29:0] EXC_VEC_DEFAULT = 30'h2FF0_00E0;

endpackage

// File: rtl/exc_ctrl_cp0_timer.sv
// CP0 Count/Compare pair: Count advances every second clock, sticky timer interrupt on match.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q    <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (count_wen)
        count <= wdata;
      else if (tick_q)
        count <= count + 32'd1;
      if (compare_wen)
        compare <= wdata;
      // Match is detected on the increment that lands on Compare, so a stale equality never re-fires.
      if (compare_wen)
        timer_int <= 1'b0;
      else if (!count_wen && tick_q && ((count + 32'd1) == compare))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt scheduler and CP0 register file for the 5-stage pipeline.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [29:0] EXC_VEC  = EXC_VEC_DEFAULT,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  int_in,
  input  logic        id_valid,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic [31:0] id_epc,
  input  logic        exe_valid,
  input  logic        exe_adel,
  input  logic        exe_ov,
  input  logic [31:0] exe_epc,
  input  logic [29:0] exe_bva,
  input  logic        mem_valid,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic        mem_eret,
  input  logic [31:0] mem_epc,
  input  logic [31:0] mem_bva,
  input  logic        cp0_wen,
  input  logic [7:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [7:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        redirect_vld,
  output logic [29:0] redirect_pc,
  input  logic        fetch_ack
);

  exc_state_e  state_q, state_d;
  logic        first_q;
  logic [29:0] redir_pc_q, redir_pc_d;
  logic [31:0] status_q, status_d, status_mtc;
  logic [31:0] epc_q, epc_d, epc_mtc;
  logic [31:0] bva_q, bva_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  sync_q [SYNC_STG];
  logic [7:0]  ip;
  logic [31:0] count, compare;
  logic        timer_int, int_pend;
  logic        take, is_eret, bva_wen;
  exc_code_e   code;
  logic [31:0] epc_src, bva_src;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_wen  (cp0_wen && (cp0_waddr == CP0_COUNT)),
    .compare_wen(cp0_wen && (cp0_waddr == CP0_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_in;
      for (int unsigned i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ip       = {sync_q[SYNC_STG-1][5] | timer_int, sync_q[SYNC_STG-1][4:0], ip_sw_q};
  assign int_pend = status_q[ST_IE] & ~status_q[ST_EXL] & (|(ip & status_q[15:8])) & mem_valid;

  // Oldest stage wins; everything is ignored while a redirect is outstanding.
  always_comb begin
    take    = 1'b0;
    is_eret = 1'b0;
    bva_wen = 1'b0;
    code    = EXC_INT;
    epc_src = '0;
    bva_src = '0;
    if (state_q == S_IDLE) begin
      take = 1'b1;
      if (int_pend) begin
        code = EXC_INT;  epc_src = mem_epc;
      end else if (mem_valid && mem_adel) begin
        code = EXC_ADEL; epc_src = mem_epc; bva_wen = 1'b1; bva_src = mem_bva;
      end else if (mem_valid && mem_ades) begin
        code = EXC_ADES; epc_src = mem_epc; bva_wen = 1'b1; bva_src = mem_bva;
      end else if (mem_valid && mem_eret) begin
        is_eret = 1'b1;
      end else if (exe_valid && exe_adel) begin
        code = EXC_ADEL; epc_src = exe_epc; bva_wen = 1'b1; bva_src = {exe_bva, 2'b00};
      end else if (exe_valid && exe_ov) begin
        code = EXC_OV;   epc_src = exe_epc;
      end else if (id_valid && id_ri) begin
        code = EXC_RI;   epc_src = id_epc;
      end else if (id_valid && id_sys) begin
        code = EXC_SYS;  epc_src = id_epc;
      end else if (id_valid && id_bp) begin
        code = EXC_BP;   epc_src = id_epc;
      end else begin
        take = 1'b0;
      end
    end
  end

  // MTC0 lands first; the taken exception then overrides the fields it owns.
  always_comb begin
    status_mtc = status_q;
    if (cp0_wen && (cp0_waddr == CP0_STATUS))
      status_mtc = (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
    epc_mtc = (cp0_wen && (cp0_waddr == CP0_EPC)) ? cp0_wdata : epc_q;
    ip_sw_d = (cp0_wen && (cp0_waddr == CP0_CAUSE)) ? cp0_wdata[9:8] : ip_sw_q;

    status_d   = status_mtc;
    epc_d      = epc_mtc;
    exc_d      = exc_q;
    bva_d      = bva_q;
    redir_pc_d = redir_pc_q;
    state_d    = state_q;
    if (take) begin
      status_d[ST_EXL] = ~is_eret;
      redir_pc_d       = is_eret ? epc_mtc[31:2] : EXC_VEC;
      state_d          = S_REDIR;
      if (!is_eret) begin
        epc_d = epc_src;
        exc_d = code;
      end
      if (bva_wen) bva_d = bva_src;
    end else if ((state_q == S_REDIR) && fetch_ack) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      redir_pc_q <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      bva_q      <= '0;
      exc_q      <= '0;
      ip_sw_q    <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= take;
      redir_pc_q <= redir_pc_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bva_q      <= bva_d;
      exc_q      <= exc_d;
      ip_sw_q    <= ip_sw_d;
    end
  end

  assign flush        = (state_q == S_REDIR) && first_q;
  assign redirect_vld = (state_q == S_REDIR);
  assign redirect_pc  = redir_pc_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = bva_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_q;
      CP0_CAUSE:    cp0_rdata = {1'b0, timer_int, 14'b0, ip, 1'b0, exc_q, 2'b00};
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus predicts taken events, a monitor checks each flush.
`timescale 1ns/1ps
module tb_exc_ctrl;

  localparam logic [29:0] VEC  = 30'h2FF0_00E0;
  localparam int unsigned SYNC = 2;
  localparam logic [7:0] A_BVA = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58,
                         A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic clk = 1'b0, reset = 1'b0;
  logic [5:0]  int_in = '0;
  logic        id_valid, id_ri, id_sys, id_bp, exe_valid, exe_adel, exe_ov;
  logic        mem_valid, mem_adel, mem_ades, mem_eret, cp0_wen, fetch_ack;
  logic [31:0] id_epc, exe_epc, mem_epc, mem_bva, cp0_wdata, cp0_rdata;
  logic [29:0] exe_bva, redirect_pc;
  logic [7:0]  cp0_waddr, cp0_raddr;
  logic        flush, redirect_vld;
  logic [7:0]  mon_raddr = '0, stim_raddr = '0;
  logic        mon_busy = 1'b0;

  assign cp0_raddr = mon_busy ? mon_raddr : stim_raddr;

  exc_ctrl #(.EXC_VEC(VEC), .SYNC_STG(SYNC)) dut (
    .clk(clk), .reset(reset), .int_in(int_in),
    .id_valid(id_valid), .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_epc(id_epc),
    .exe_valid(exe_valid), .exe_adel(exe_adel), .exe_ov(exe_ov), .exe_epc(exe_epc), .exe_bva(exe_bva),
    .mem_valid(mem_valid), .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_eret(mem_eret),
    .mem_epc(mem_epc), .mem_bva(mem_bva),
    .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .flush(flush), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .fetch_ack(fetch_ack)
  );

  always #10 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] epc;
    logic [4:0]  code;
    logic [31:0] status;
    logic [31:0] bva;
  } exp_t;
  exp_t expq[$];

  // Architectural view of CP0 as software sees it
  logic [31:0] m_status, m_epc, m_bva;
  logic [4:0]  m_code;
  logic [1:0]  m_sw;
  logic        m_ti;

  task automatic model_reset();
    m_status = 32'h0040_0000; m_epc = '0; m_bva = '0; m_code = '0; m_sw = '0; m_ti = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stim_rd(input logic [7:0] a, output logic [31:0] d);
    stim_raddr = a; #1; d = cp0_rdata;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_epc = '0;
    exe_valid = 0; exe_adel = 0; exe_ov = 0; exe_epc = '0; exe_bva = '0;
    mem_valid = 0; mem_adel = 0; mem_ades = 0; mem_eret = 0; mem_epc = '0; mem_bva = '0;
    cp0_wen = 0; cp0_waddr = '0; cp0_wdata = '0; fetch_ack = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    case (a)
      A_COMPARE: m_ti = 1'b0;
      A_STATUS:  m_status = (m_status & ~32'h0000_FF03) | (d & 32'h0000_FF03);
      A_CAUSE:   m_sw = d[9:8];
      A_EPC:     m_epc = d;
      default: ;
    endcase
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    cp0_wen = 1; cp0_waddr = a; cp0_wdata = d;
    model_write(a, d);
    cycle();
    cp0_wen = 0;
  endtask

  // Decide from the currently driven inputs which single event the rules select.
  task automatic predict(output bit taken);
    logic [7:0]  ipv;
    logic        intp;
    logic [31:0] ep, bv;
    logic [4:0]  c;
    bit          bvw, er;
    exp_t        e;
    ipv  = {int_in[5] | m_ti, int_in[4:0], m_sw};
    intp = m_status[0] & ~m_status[1] & (|(ipv & m_status[15:8])) & mem_valid;
    if (cp0_wen) model_write(cp0_waddr, cp0_wdata);
    taken = 1; er = 0; bvw = 0; c = 0; ep = '0; bv = '0;
    if (intp)                        begin c = 0;  ep = mem_epc; end
    else if (mem_valid && mem_adel)  begin c = 4;  ep = mem_epc; bvw = 1; bv = mem_bva; end
    else if (mem_valid && mem_ades)  begin c = 5;  ep = mem_epc; bvw = 1; bv = mem_bva; end
    else if (mem_valid && mem_eret)  er = 1;
    else if (exe_valid && exe_adel)  begin c = 4;  ep = exe_epc; bvw = 1; bv = {exe_bva, 2'b00}; end
    else if (exe_valid && exe_ov)    begin c = 12; ep = exe_epc; end
    else if (id_valid && id_ri)      begin c = 10; ep = id_epc; end
    else if (id_valid && id_sys)     begin c = 8;  ep = id_epc; end
    else if (id_valid && id_bp)      begin c = 9;  ep = id_epc; end
    else taken = 0;
    if (taken) begin
      if (er) begin
        m_status[1] = 1'b0;
        e.pc = m_epc[31:2];
      end else begin
        m_status[1] = 1'b1;
        m_epc = ep; m_code = c;
        if (bvw) m_bva = bv;
        e.pc = VEC;
      end
      e.epc = m_epc; e.code = m_code; e.status = m_status; e.bva = m_bva;
      expq.push_back(e);
    end
  endtask

  // Apply the driven event for one edge, then hold the redirect for `hold` cycles before acking.
  task automatic fire(input int unsigned hold);
    bit tk;
    predict(tk);
    cycle();
    clear_inputs();
    if (tk) begin
      for (int unsigned i = 0; i < hold; i++) begin
        chk("redirect_held", 32'(redirect_vld), 32'd1);
        if ($urandom_range(0, 1) == 1) begin id_valid = 1; id_bp = 1; id_epc = $urandom; end
        cycle();
        id_valid = 0; id_bp = 0;
      end
      chk("redirect_before_ack", 32'(redirect_vld), 32'd1);
      fetch_ack = 1;
      cycle();
      fetch_ack = 0;
      chk("redirect_dropped", 32'(redirect_vld), 32'd0);
    end else begin
      chk("no_redirect", 32'(redirect_vld), 32'd0);
    end
  endtask

  // Monitor: every flush must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && flush === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_flush", 32'(flush), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("flush_redirect_vld", 32'(redirect_vld), 32'd1);
          chk("redirect_pc", 32'(redirect_pc), 32'(e.pc));
          mon_busy = 1;
          mon_raddr = A_EPC;    #1; d = cp0_rdata; chk("epc", d, e.epc);
          mon_raddr = A_STATUS; #1; d = cp0_rdata; chk("status", d, e.status);
          mon_raddr = A_CAUSE;  #1; d = cp0_rdata; chk("exccode", 32'(d[6:2]), 32'(e.code));
          mon_raddr = A_BVA;    #1; d = cp0_rdata; chk("badvaddr", d, e.bva);
          mon_busy = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit tk;
    clear_inputs();
    model_reset();
    #15;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_vld", 32'(redirect_vld), 32'd0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    stim_rd(A_STATUS, d); chk("rst_status", d, 32'h0040_0000);
    stim_rd(A_CAUSE, d);  chk("rst_cause", d, 32'd0);
    stim_rd(A_EPC, d);    chk("rst_epc", d, 32'd0);
    @(posedge clk); #1; reset = 1;
    cycle();

    // Overflow in EXE
    exe_valid = 1; exe_ov = 1; exe_epc = 32'h100;
    fire(1);

    // AdES in MEM beats syscall in ID
    mem_valid = 1; mem_ades = 1; mem_bva = 32'h203; mem_epc = 32'h300;
    id_valid = 1; id_sys = 1; id_epc = 32'h308;
    fire(0);

    // ERET back to 0x400, redirect held 3 cycles
    mtc0(A_EPC, 32'h400);
    mem_valid = 1; mem_eret = 1; mem_epc = 32'h500;
    fire(3);

    // Random mixes, occasionally with a simultaneous MTC0
    for (int n = 0; n < 300; n++) begin
      id_valid  = 1'($urandom_range(0, 1)); id_ri = ($urandom_range(0, 7) == 0);
      id_sys    = ($urandom_range(0, 5) == 0); id_bp = ($urandom_range(0, 5) == 0);
      id_epc    = $urandom;
      exe_valid = 1'($urandom_range(0, 1)); exe_adel = ($urandom_range(0, 6) == 0);
      exe_ov    = ($urandom_range(0, 5) == 0); exe_epc = $urandom; exe_bva = 30'($urandom);
      mem_valid = 1'($urandom_range(0, 1)); mem_adel = ($urandom_range(0, 7) == 0);
      mem_ades  = ($urandom_range(0, 7) == 0); mem_eret = ($urandom_range(0, 6) == 0);
      mem_epc   = $urandom; mem_bva = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        cp0_wen = 1; cp0_wdata = $urandom;
        cp0_waddr = ($urandom_range(0, 1) == 1) ? A_STATUS : A_EPC;
      end
      fire($urandom_range(0, 3));
    end

    // Timer interrupt
    mtc0(A_STATUS, 32'h0);
    mtc0(A_COUNT, 32'h0);
    mtc0(A_COMPARE, 32'h5);
    stim_rd(A_CAUSE, d); chk("ti_clear_initially", 32'(d[30]), 32'd0);
    repeat (14) cycle();
    m_ti = 1'b1;
    stim_rd(A_CAUSE, d);
    chk("ti_set", 32'(d[30]), 32'd1);
    chk("ip7_from_timer", 32'(d[15]), 32'd1);
    mtc0(A_STATUS, 32'h0000_8001);
    mem_valid = 1; mem_epc = 32'h1234_5678;
    fire(1);
    mtc0(A_COMPARE, 32'hFFFF_0000);
    stim_rd(A_CAUSE, d); chk("ti_cleared_by_compare", 32'(d[30]), 32'd0);
    mem_valid = 1; mem_eret = 1;
    fire(0);

    // Hardware interrupt masked by EXL until ERET
    mtc0(A_STATUS, 32'h0000_0403);
    int_in = 6'b000001;
    stim_rd(A_CAUSE, d); chk("ip2_not_yet_synced", 32'(d[10]), 32'd0);
    repeat (SYNC) cycle();
    stim_rd(A_CAUSE, d); chk("ip2_visible", 32'(d[10]), 32'd1);
    mem_valid = 1; mem_epc = 32'hAB00;
    fire(0);
    mem_valid = 1; mem_eret = 1; mem_epc = 32'hAB04;
    fire(1);
    mem_valid = 1; mem_epc = 32'hABC0;
    fire(0);
    int_in = '0;
    mtc0(A_STATUS, 32'h0);
    repeat (SYNC + 1) cycle();

    // Reset asserted in the middle of a redirect
    id_valid = 1; id_bp = 1; id_epc = 32'h0000_0AB0;
    predict(tk);
    cycle();
    clear_inputs();
    cycle();
    id_valid = 1; id_bp = 1;
    #2 reset = 0;
    #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_redirect_vld", 32'(redirect_vld), 32'd0);
    chk("midrst_redirect_pc", 32'(redirect_pc), 32'd0);
    stim_rd(A_STATUS, d); chk("midrst_status", d, 32'h0040_0000);
    stim_rd(A_EPC, d);    chk("midrst_epc", d, 32'd0);
    stim_rd(A_CAUSE, d);  chk("midrst_cause", d, 32'd0);
    stim_rd(A_BVA, d);    chk("midrst_badvaddr", d, 32'd0);
    stim_rd(A_COUNT, d);  chk("midrst_count", d, 32'd0);
    model_reset();
    clear_inputs();
    cycle();
    reset = 1;
    cycle();
    chk("post_reset_idle", 32'(redirect_vld), 32'd0);
    cycle();

    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
